// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor
//
// Unsigned A - B over NIBBLES 4-bit slices. One slice is processed per
// clock, least-significant first, with the borrow chained between slices.
// Operands are captured on an accepted start. The wide result and its flags
// are registered, and they update only when the last slice completes.
//
// Ports
//   clk    : single clock; all state updates on the rising edge
//   rst    : synchronous reset, active-high; aborts any operation in flight
//   start  : request; accepted only in IDLE or DONE
//   a, b   : minuend / subtrahend (W = 4*NIBBLES bits), captured on accept
//   busy   : high while slices are being processed
//   done   : one-cycle pulse, result outputs were just updated
//   diff   : registered A - B mod 2^W
//   borrow : final borrow out, 1 iff A < B
//   zero   : 1 iff diff == 0

module nibble_serial_subtractor #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   diff,
    output logic                   borrow,
    output logic                   zero
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       work_q;
    logic [IDX_W-1:0]   idx_q;
    logic               bin_q;
    logic               busy_q;
    logic               done_q;
    logic [W-1:0]       diff_q;
    logic               borrow_q;
    logic               zero_q;

    // Slice views of the captured operands.
    logic [3:0] a_sl [NIBBLES];
    logic [3:0] b_sl [NIBBLES];

    // Current slice arithmetic.
    logic [4:0]   sub_d;
    logic [3:0]   slice_d;
    logic         bout_d;
    // Working result with the current slice already merged in. On the last
    // slice this is the complete difference, so it can go straight to diff.
    logic [W-1:0] work_d;

    genvar gi;
    generate
        for (gi = 0; gi < NIBBLES; gi++) begin : g_slice
            assign a_sl[gi] = a_q[4*gi +: 4];
            assign b_sl[gi] = b_q[4*gi +: 4];
            assign work_d[4*gi +: 4] = (idx_q == IDX_W'(gi)) ? slice_d
                                                             : work_q[4*gi +: 4];
        end
    endgenerate

    // 5-bit subtract: bit 4 is the borrow out of this slice.
    always_comb begin
        sub_d   = {1'b0, a_sl[idx_q]} - {1'b0, b_sl[idx_q]} - {4'b0000, bin_q};
        slice_d = sub_d[3:0];
        bout_d  = sub_d[4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            idx_q    <= '0;
            bin_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        work_q  <= '0;
                        idx_q   <= '0;
                        bin_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    work_q <= work_d;
                    bin_q  <= bout_d;
                    idx_q  <= idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        diff_q   <= work_d;
                        borrow_q <= bout_d;
                        zero_q   <= (work_d == '0);
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        idx_q    <= '0;
                        state_q  <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Testbench for nibble_serial_subtractor (NIBBLES = 4, W = 16).
// The stimulus pushes expected results into a queue. A monitor on the
// falling edge pops and compares on every done pulse. Between done pulses
// it checks that the outputs stay stable.

module tb_nibble_serial_subtractor;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         zero;

    nibble_serial_subtractor #(.NIBBLES(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         borrow;
        logic         zero;
    } res_t;

    res_t exp_q[$];
    res_t last;
    int   tests = 0;
    int   fails = 0;
    int   ops   = 0;
    logic rst_at_edge = 1'b0;

    always @(posedge clk) rst_at_edge = rst;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        res_t cur;
        res_t e;
        cur = '{diff: diff, borrow: borrow, zero: zero};
        if (rst_at_edge) begin
            last = cur;
        end else if (done === 1'b1) begin
            ops++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("[TB] FAIL unexpected_done: got diff=%h borrow=%b zero=%b expected no done",
                         diff, borrow, zero);
            end else begin
                e = exp_q.pop_front();
                if (cur !== e) begin
                    fails++;
                    $display("[TB] FAIL result op %0d: got diff=%h borrow=%b zero=%b expected diff=%h borrow=%b zero=%b",
                             ops, diff, borrow, zero, e.diff, e.borrow, e.zero);
                end else begin
                    $display("[TB] op %0d: diff=%h borrow=%b zero=%b ok", ops, diff, borrow, zero);
                end
            end
            tests++;
            if (borrow === 1'b1 && zero === 1'b1) begin
                fails++;
                $display("[TB] FAIL flags_exclusive: got borrow=1 zero=1 expected not both");
            end
            last = cur;
        end else begin
            tests++;
            if (cur !== last) begin
                fails++;
                $display("[TB] FAIL hold: got diff=%h borrow=%b zero=%b expected diff=%h borrow=%b zero=%b",
                         diff, borrow, zero, last.diff, last.borrow, last.zero);
                last = cur;
            end
        end
    end

    // Waits for done, which must arrive exactly N cycles after the cycle
    // following the accepting edge.
    task automatic wait_done();
        int cyc;
        bit got;
        got = 1'b0;
        cyc = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) got = 1'b1;
        end
        if (!got) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("done_latency", cyc, N);
        end
    endtask

    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input res_t e);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        check("busy_run", {31'd0, busy}, 32'd1);
        wait_done();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        res_t e;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("rst_busy",   {31'd0, busy},   32'd0);
        check("rst_done",   {31'd0, done},   32'd0);
        check("rst_diff",   {16'd0, diff},   32'd0);
        check("rst_borrow", {31'd0, borrow}, 32'd0);
        check("rst_zero",   {31'd0, zero},   32'd0);
        rst = 1'b0;

        // 0x1234 - 0x0234 with cycle-accurate busy/done timing.
        @(negedge clk);
        a = 16'h1234; b = 16'h0234; start = 1'b1;
        exp_q.push_back('{diff: 16'h1000, borrow: 1'b0, zero: 1'b0});
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            check($sformatf("t1_busy_c%0d", i), {31'd0, busy}, {31'd0, (i <= 4)});
            check($sformatf("t1_done_c%0d", i), {31'd0, done}, {31'd0, (i == 5)});
        end

        // Borrow ripples through every slice.
        do_op(16'h0000, 16'h0001, '{diff: 16'hFFFF, borrow: 1'b1, zero: 1'b0});
        do_op(16'hABCD, 16'hABCD, '{diff: 16'h0000, borrow: 1'b0, zero: 1'b1});
        do_op(16'h8000, 16'h0001, '{diff: 16'h7FFF, borrow: 1'b0, zero: 1'b0});

        // start during busy is ignored; start on the done cycle is accepted.
        @(negedge clk);
        a = 16'h0010; b = 16'h0001; start = 1'b1;
        exp_q.push_back('{diff: 16'h000F, borrow: 1'b0, zero: 1'b0});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("t4_busy_c4", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("t4_done_c5", {31'd0, done}, 32'd1);
        a = 16'h0005; b = 16'h0007; start = 1'b1;
        exp_q.push_back('{diff: 16'hFFFE, borrow: 1'b1, zero: 1'b0});
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            check($sformatf("b2b_busy_c%0d", i), {31'd0, busy}, {31'd0, (i <= 4)});
            check($sformatf("b2b_done_c%0d", i), {31'd0, done}, {31'd0, (i == 5)});
        end

        // Reset in cycle 3 of an operation aborts it.
        @(negedge clk);
        a = 16'h1234; b = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy",   {31'd0, busy},   32'd0);
        check("abort_done",   {31'd0, done},   32'd0);
        check("abort_diff",   {16'd0, diff},   32'd0);
        check("abort_borrow", {31'd0, borrow}, 32'd0);
        check("abort_zero",   {31'd0, zero},   32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_no_done", {31'd0, done}, 32'd0);
        end
        do_op(16'h0100, 16'h00FF, '{diff: 16'h0001, borrow: 1'b0, zero: 1'b0});

        // Random operand pairs against the (a-b) mod 2^16 model.
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            ra = 16'($urandom);
            rb = (n % 10 == 0) ? ra : 16'($urandom);
            e.diff   = ra - rb;
            e.borrow = (ra < rb);
            e.zero   = (ra == rb);
            do_op(ra, rb, e);
        end

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nibble_serial_subtractor.md
Name: nibble_serial_subtractor

Overview:
- Multi-nibble unsigned subtractor computing A - B over NIBBLES 4-bit slices, one slice per clock, least-significant first, with borrow chained between slices.
- Uses the same per-slice arithmetic as the 4-bit subtract stage: a 4-bit difference plus a borrow bit.
- Sits next to the ALU subtract path. It accepts wide operands through a start/busy/done handshake and delivers a registered wide result with borrow and zero flags to the ALU output mux.

Parameters:
NIBBLES, 4, number of 4-bit slices; operand/result width W = 4*NIBBLES (minimum 1)

Ports:
clk    input   1    single clock; all state updates on rising edge
rst    input   1    synchronous reset, active-high
start  input   1    request; sampled only when ready (state IDLE or DONE)
a      input   W    minuend, captured on accepted start
b      input   W    subtrahend, captured on accepted start
busy   output  1    high while slices are being processed (state RUN)
done   output  1    one-cycle pulse: result outputs just updated
diff   output  W    registered difference A - B mod 2^W
borrow output  1    final borrow out; 1 iff A < B (unsigned)
zero   output  1    1 iff diff == 0

Behaviour:
- Reset and state machine:
  - Clock and reset: one clock, clk; synchronous active-high reset, rst.
  - rst high at an edge forces state IDLE, slice index 0, internal borrow 0, internal operand/working registers 0, and busy=0, done=0, diff=0, borrow=0, zero=0.
  - rst overrides start and aborts any operation in progress; no done is produced for an aborted operation.
  - States: IDLE, RUN, DONE.
  - IDLE: start=1 latches a and b, sets idx=0 and carry-borrow=0, then goes to RUN. start=0 stays in IDLE.
  - RUN: every edge processes slice idx as {bout, d} = {0,a[idx]} - {0,b[idx]} - bin. d is written to working slice idx, bin <= bout, idx <= idx+1.
  - RUN, last slice (idx == NIBBLES-1): diff <= full working result including d, borrow <= bout, zero <= (result == 0). State goes to DONE.
  - DONE: done=1 for exactly this cycle. start=1 here is accepted exactly as in IDLE (back-to-back operation); otherwise the next state is IDLE.
- Handshake and timing:
  - busy=1 exactly in RUN. start while busy is ignored and has no effect on the operation in flight.
  - Latency: start high in cycle 0 gives busy in cycles 1..NIBBLES and done in cycle NIBBLES+1. Throughput is one result per NIBBLES+1 cycles.
  - a and b may change freely after the accepting edge; only captured copies are used.
- Output holding:
  - diff, borrow and zero change only on the DONE-entry edge or on reset.
  - They hold their last value through IDLE and through the next RUN.
- Arithmetic:
  - Unsigned, modulo 2^W. Wrap-around is reported through borrow only; there is no signed overflow flag.
  - zero and borrow can never both be 1.
- NIBBLES=1 degenerates to a single RUN cycle, with done in cycle 2.

Test Plan:
- NIBBLES=4, a=0x1234, b=0x0234, start 1 cycle -> busy cycles 1-4, done cycle 5, diff=0x1000, borrow=0, zero=0.
- a=0x0000, b=0x0001 -> diff=0xFFFF, borrow=1, zero=0; the borrow ripples through all four slices.
- a=0xABCD, b=0xABCD -> diff=0x0000, borrow=0, zero=1. Then a=0x8000, b=0x0001 -> diff=0x7FFF, borrow=0, zero=0.
- Start 0x0010-0x0001, then pulse start with a=0xFFFF, b=0 during cycle 2 (busy) -> ignored; done cycle 5, diff=0x000F. Then start held high on the done cycle with 0x0005-0x0007 -> accepted; next done 5 cycles later, diff=0xFFFE, borrow=1.
- rst asserted in cycle 3 of an operation -> next cycle busy=0, done=0, diff=0, flags 0; no done pulse follows. A new start afterwards computes 0x0100-0x00FF -> diff=0x0001.
- Randomized 1000 operand pairs with random start gaps -> each done cycle matches the reference model (a-b) mod 2^16, borrow=(a<b), zero=(a==b). Outputs stable between done pulses.
